// File: rtl/writeback_unit_pkg.sv
// Shared constants and the load-buffer entry type for the writeback stage.
package writeback_unit_pkg;

    localparam int unsigned REG_NUM_W = 5;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_REGS  = 32;

    localparam logic [REG_NUM_W-1:0] REG_ZERO = 5'd0;

    // One buffered load response: destination register and data.
    typedef struct packed {
        logic [REG_NUM_W-1:0] rd_num;
        logic [XLEN-1:0]      val;
    } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback bus: ALU results, load responses, issue marks, hazard checks, RF write port.
// Optional forwarding outputs exist only when WRITEBACK_FWD_EN is defined.
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic                 i_alu_valid;
    logic [REG_NUM_W-1:0] i_alu_rd_num;
    logic [XLEN-1:0]      i_alu_val;
    logic                 i_ld_valid;
    logic [REG_NUM_W-1:0] i_ld_rd_num;
    logic [XLEN-1:0]      i_ld_val;
    logic                 o_ld_ready;
    logic                 i_issue_valid;
    logic [REG_NUM_W-1:0] i_issue_rd_num;
    logic [REG_NUM_W-1:0] i_chk_num_1;
    logic [REG_NUM_W-1:0] i_chk_num_2;
    logic [REG_NUM_W-1:0] i_chk_rd;
    logic                 o_stall;
    logic                 o_w_op;
    logic [XLEN-1:0]      o_w_rd;
    logic [REG_NUM_W-1:0] o_w_rd_num;
`ifdef WRITEBACK_FWD_EN
    logic                 o_fwd_1_valid;
    logic [XLEN-1:0]      o_fwd_1;
    logic                 o_fwd_2_valid;
    logic [XLEN-1:0]      o_fwd_2;
`endif

    modport slave (
        input  i_alu_valid, i_alu_rd_num, i_alu_val,
        input  i_ld_valid, i_ld_rd_num, i_ld_val,
        input  i_issue_valid, i_issue_rd_num,
        input  i_chk_num_1, i_chk_num_2, i_chk_rd,
        output o_ld_ready, o_stall, o_w_op, o_w_rd, o_w_rd_num
`ifdef WRITEBACK_FWD_EN
        , output o_fwd_1_valid, o_fwd_1, o_fwd_2_valid, o_fwd_2
`endif
    );

    modport master (
        output i_alu_valid, i_alu_rd_num, i_alu_val,
        output i_ld_valid, i_ld_rd_num, i_ld_val,
        output i_issue_valid, i_issue_rd_num,
        output i_chk_num_1, i_chk_num_2, i_chk_rd,
        input  o_ld_ready, o_stall, o_w_op, o_w_rd, o_w_rd_num
`ifdef WRITEBACK_FWD_EN
        , input o_fwd_1_valid, o_fwd_1, o_fwd_2_valid, o_fwd_2
`endif
    );

endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// Load-response FIFO; pointers carry an extra wrap bit to tell full from empty.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  wb_entry_t i_din,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    wb_entry_t     mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    // Pointer advance on push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (i_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_ptr_q[AW-1:0]] <= i_din;
    end

    assign o_head  = mem_q[rd_ptr_q[AW-1:0]];
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_empty = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and buffered loads onto the RF write port,
// and tracks registers awaiting load data for decode hazard stalls.
// Optional macro WRITEBACK_FWD_EN adds same-cycle bypass outputs.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    writeback_unit_if.slave  bus
);
    wb_entry_t             ld_entry;
    wb_entry_t             fifo_head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic                  w_op_q, w_op_d;
    logic [XLEN-1:0]       w_rd_q, w_rd_d;
    logic [REG_NUM_W-1:0]  w_rd_num_q, w_rd_num_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    // ALU owns the port whenever valid; loads drain only in idle ALU cycles.
    always_comb begin
        ld_entry.rd_num = bus.i_ld_rd_num;
        ld_entry.val    = bus.i_ld_val;
        fifo_push       = bus.i_ld_valid && !fifo_full;
        fifo_pop        = !bus.i_alu_valid && !fifo_empty;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_din   (ld_entry),
        .i_pop   (fifo_pop),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Output select and scoreboard update; an issue wins over a same-edge clear.
    always_comb begin
        w_op_d     = 1'b0;
        w_rd_d     = w_rd_q;
        w_rd_num_d = w_rd_num_q;
        pending_d  = pending_q;
        if (bus.i_alu_valid) begin
            w_op_d     = (bus.i_alu_rd_num != REG_ZERO);
            w_rd_d     = bus.i_alu_val;
            w_rd_num_d = bus.i_alu_rd_num;
        end else if (fifo_pop) begin
            w_op_d     = (fifo_head.rd_num != REG_ZERO);
            w_rd_d     = fifo_head.val;
            w_rd_num_d = fifo_head.rd_num;
            pending_d[fifo_head.rd_num] = 1'b0;
        end
        if (bus.i_issue_valid) pending_d[bus.i_issue_rd_num] = 1'b1;
        pending_d[REG_ZERO] = 1'b0;
    end

    // Write-port and scoreboard registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            w_op_q     <= 1'b0;
            w_rd_q     <= '0;
            w_rd_num_q <= '0;
            pending_q  <= '0;
        end else begin
            w_op_q     <= w_op_d;
            w_rd_q     <= w_rd_d;
            w_rd_num_q <= w_rd_num_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.o_w_op     = w_op_q;
    assign bus.o_w_rd     = w_rd_q;
    assign bus.o_w_rd_num = w_rd_num_q;
    assign bus.o_ld_ready = !fifo_full;
    assign bus.o_stall    = pending_q[bus.i_chk_num_1] | pending_q[bus.i_chk_num_2]
                          | pending_q[bus.i_chk_rd];

`ifdef WRITEBACK_FWD_EN
    // Bypass the write happening this cycle to decode's source operands.
    assign bus.o_fwd_1_valid = w_op_q && (w_rd_num_q == bus.i_chk_num_1) && (w_rd_num_q != REG_ZERO);
    assign bus.o_fwd_2_valid = w_op_q && (w_rd_num_q == bus.i_chk_num_2) && (w_rd_num_q != REG_ZERO);
    assign bus.o_fwd_1       = w_rd_q;
    assign bus.o_fwd_2       = w_rd_q;
`endif

endmodule
